tt_clk_div_ctrl: RTL

//  Sequences ratio changes of the programmable feedback-clock divider (next to tt_divide_by_3 in the clock path).

---
 rtl/tt_clk_div_pkg.sv | 37 +++
 rtl/tt_clk_div_ctrl_if.sv | 21 ++
 rtl/tt_clk_div_ctrl_cnt.sv | 40 ++++
 rtl/tt_clk_div_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/tt_clk_div_pkg.sv
// Shared types and helpers for the feedback-clock divider ratio-change controller.
package tt_clk_div_pkg;

  localparam int unsigned RATIO_W   = 4;
  localparam int unsigned RATIO_MIN = 2;

  typedef logic [RATIO_W-1:0] ratio_t;

  typedef enum logic [2:0] {
    StLocked = 3'd0,
    StDrain  = 3'd1,
    StGate   = 3'd2,
    StLoad   = 3'd3,
    StSettle = 3'd4
  } clk_div_state_e;

  localparam logic [2:0] ST_LOCKED = StLocked;
  localparam logic [2:0] ST_DRAIN  = StDrain;
  localparam logic [2:0] ST_GATE   = StGate;
  localparam logic [2:0] ST_LOAD   = StLoad;
  localparam logic [2:0] ST_SETTLE = StSettle;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Counters are cleared to 0 and count down, so after k events they hold -k mod 2^w.
  // This returns the value seen while the n-th event is being processed.
  function automatic int unsigned cnt_last(input int unsigned n, input int unsigned w);
    return ((32'd1 << w) - (n - 32'd1)) % (32'd1 << w);
  endfunction

  function automatic ratio_t clamp_ratio(input ratio_t r);
    return (r < ratio_t'(RATIO_MIN)) ? ratio_t'(RATIO_MIN) : r;
  endfunction

endpackage

// File: rtl/tt_clk_div_ctrl_if.sv
// Ratio-change request handshake between a requester and tt_clk_div_ctrl.
interface tt_clk_div_ctrl_if;
  import tt_clk_div_pkg::*;

  logic   req_valid;
  logic   req_ready;
  ratio_t req_ratio;

  modport master (
    output req_valid,
    output req_ratio,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_ratio,
    output req_ready
  );

endinterface

// File: rtl/tt_clk_div_ctrl_cnt.sv
// Loadable down-counter with scan shift; bit 0 is the scan entry, the MSB is the scan exit.
module tt_clk_div_ctrl_cnt #(
  parameter int unsigned W = 2
) (
  input  logic         i_clk_gen,
  input  logic         i_rst_n,
  input  logic         i_scan_en,
  input  logic         i_scan_in,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt,
  output logic         o_scan_out
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_scan_en) begin
      cnt_d = W'({cnt_q, i_scan_in});
    end else if (i_load) begin
      cnt_d = i_load_val;
    end else if (i_dec) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge i_clk_gen or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt      = cnt_q;
  assign o_scan_out = cnt_q[W-1];

endmodule

// File: rtl/tt_clk_div_ctrl.sv
// Sequences glitch-free ratio changes of the feedback-clock divider.
// Optional DRAIN timeout with sticky o_err: define CLK_DIV_CTRL_TIMEOUT_EN.
module tt_clk_div_ctrl
  import tt_clk_div_pkg::*;
#(
  parameter int unsigned DEFAULT_RATIO  = 3,
  parameter int unsigned GATE_CYCLES    = 2,
  parameter int unsigned SETTLE_TCS     = 4
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
  input  logic             i_clk_gen,
  input  logic             i_rst_n,
  tt_clk_div_ctrl_if.slave req,
  input  logic             i_div_tc,
  output logic             o_div_en,
  output ratio_t           o_div_ratio,
  output logic             o_locked,
  output logic             o_busy,
  output logic             o_err,
  input  logic             i_scan_en,
  input  logic             i_scan_in,
  output logic             o_scan_out
);

  localparam int unsigned GateW   = cnt_width(GATE_CYCLES);
  localparam int unsigned SettleW = cnt_width(SETTLE_TCS);
  localparam logic [GateW-1:0]   GateLast   = GateW'(cnt_last(GATE_CYCLES, GateW));
  localparam logic [SettleW-1:0] SettleLast = SettleW'(cnt_last(SETTLE_TCS, SettleW));

  logic [2:0] state_q, state_d;
  ratio_t     pend_q, pend_d;
  ratio_t     ratio_q, ratio_d;

  logic [GateW-1:0]   gate_cnt;
  logic [SettleW-1:0] settle_cnt;
  logic               gate_so, settle_so;

  logic in_drain, in_gate, in_settle;
  assign in_drain  = (state_q == ST_DRAIN);
  assign in_gate   = (state_q == ST_GATE);
  assign in_settle = (state_q == ST_SETTLE);

`ifdef CLK_DIV_CTRL_TIMEOUT_EN
  localparam int unsigned ToutW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [ToutW-1:0] ToutLast = ToutW'(cnt_last(TIMEOUT_CYCLES, ToutW));

  logic [ToutW-1:0] tout_cnt;
  logic             tout_so;
  logic             err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    ratio_d = ratio_q;
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
    err_d   = err_q;
`endif
    if (i_scan_en) begin
      state_d = 3'({state_q, i_scan_in});
      pend_d  = ratio_t'({pend_q, state_q[2]});
      ratio_d = ratio_t'({ratio_q, pend_q[RATIO_W-1]});
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
      err_d   = tout_so;
`endif
    end else begin
      unique case (state_q)
        ST_LOCKED: begin
          if (req.req_valid) begin
            pend_d = clamp_ratio(req.req_ratio);
            if (pend_d != ratio_q) state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (i_div_tc) begin
            state_d = ST_GATE;
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
          end else if (tout_cnt == ToutLast) begin
            err_d   = 1'b1;
            state_d = ST_GATE;
`endif
          end
        end
        ST_GATE: begin
          if (gate_cnt == GateLast) state_d = ST_LOAD;
        end
        ST_LOAD: begin
          ratio_d = pend_q;
          state_d = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (i_div_tc && (settle_cnt == SettleLast)) state_d = ST_LOCKED;
        end
        // Encodings 5..7 are only reachable by scan load; recover by re-settling.
        default: state_d = ST_SETTLE;
      endcase
    end
  end

  always_ff @(posedge i_clk_gen or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_SETTLE;
      pend_q  <= ratio_t'(DEFAULT_RATIO);
      ratio_q <= ratio_t'(DEFAULT_RATIO);
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ratio_q <= ratio_d;
    end
  end

  // Each counter is held at 0 outside its own state.
  tt_clk_div_ctrl_cnt #(
    .W (GateW)
  ) u_gate_cnt (
    .i_clk_gen  (i_clk_gen),
    .i_rst_n    (i_rst_n),
    .i_scan_en  (i_scan_en),
    .i_scan_in  (ratio_q[RATIO_W-1]),
    .i_load     (!in_gate),
    .i_load_val ('0),
    .i_dec      (in_gate),
    .o_cnt      (gate_cnt),
    .o_scan_out (gate_so)
  );

  tt_clk_div_ctrl_cnt #(
    .W (SettleW)
  ) u_settle_cnt (
    .i_clk_gen  (i_clk_gen),
    .i_rst_n    (i_rst_n),
    .i_scan_en  (i_scan_en),
    .i_scan_in  (gate_so),
    .i_load     (!in_settle),
    .i_load_val ('0),
    .i_dec      (in_settle && i_div_tc),
    .o_cnt      (settle_cnt),
    .o_scan_out (settle_so)
  );

`ifdef CLK_DIV_CTRL_TIMEOUT_EN
  tt_clk_div_ctrl_cnt #(
    .W (ToutW)
  ) u_tout_cnt (
    .i_clk_gen  (i_clk_gen),
    .i_rst_n    (i_rst_n),
    .i_scan_en  (i_scan_en),
    .i_scan_in  (settle_so),
    .i_load     (!in_drain),
    .i_load_val ('0),
    .i_dec      (in_drain && !i_div_tc),
    .o_cnt      (tout_cnt),
    .o_scan_out (tout_so)
  );

  always_ff @(posedge i_clk_gen or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign o_err      = err_q;
  assign o_scan_out = err_q;
`else
  assign o_err      = 1'b0;
  assign o_scan_out = settle_so;
`endif

  assign o_div_en      = !(in_gate || (state_q == ST_LOAD));
  assign o_div_ratio   = ratio_q;
  assign o_locked      = (state_q == ST_LOCKED);
  assign o_busy        = !o_locked;
  assign req.req_ready = o_locked;

endmodule
